// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
//   Shares one uart_tx serializer between N_REQ byte producers. A round-robin
//   arbiter picks one producer per frame. The block drives the serializer's
//   send_request/tx_data/parity_enable, follows its tx_busy/tx_done handshake,
//   and generates the free-running baud_tick that the serializer consumes.
//
// Ports
//   clk, reset_n   system clock (posedge) / asynchronous active-low reset
//   req_valid      per-requester "byte pending" level
//   req_data       packed bytes, requester i = req_data[8*i +: 8]
//   req_ready      one-hot accept (combinational, only while IDLE)
//   req_done       1-cycle pulse when requester i's frame has finished
//   parity_cfg     parity enable, captured at accept
//   baud_tick      1-cycle pulse every CLKS_PER_BAUD clocks
//   send_request   start-frame request to uart_tx
//   tx_data        byte presented to uart_tx
//   parity_enable  parity setting presented to uart_tx
//   tx_busy        uart_tx frame in progress
//   tx_done        uart_tx frame complete pulse
//   sched_busy     scheduler not IDLE
//   grant_id       index of the requester that owns the current frame
//   err_timeout    1-cycle pulse: uart_tx never raised tx_busy, launch aborted
// -----------------------------------------------------------------------------
module uart_tx_sched #(
  parameter int N_REQ          = 4,
  parameter int CLKS_PER_BAUD  = 55,
  parameter int LAUNCH_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           req_done,
  input  logic                       parity_cfg,
  output logic                       baud_tick,
  output logic                       send_request,
  output logic [7:0]                 tx_data,
  output logic                       parity_enable,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic                       sched_busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       err_timeout
);

  localparam int IDW = $clog2(N_REQ);
  localparam int BW  = $clog2(CLKS_PER_BAUD);
  localparam int TW  = $clog2(LAUNCH_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [BW-1:0]      baud_cnt_q;
  logic               baud_tick_q;
  logic [TW-1:0]      to_cnt_q;
  logic               send_q, parity_q, err_q;
  logic [7:0]         data_q;
  logic [IDW-1:0]     grant_q;
  logic [N_REQ-1:0]   done_q;

  logic               grant_found;
  logic [IDW-1:0]     grant_idx;
  logic               accept;

  // ---------------------------------------------------------------------------
  // Baud generator: free-running, independent of the scheduler FSM.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop, regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_cnt_q  <= '0;
      baud_tick_q <= 1'b0;
    end else begin
      baud_tick_q <= (baud_cnt_q == BW'(CLKS_PER_BAUD - 1));
      if (baud_cnt_q == BW'(CLKS_PER_BAUD - 1)) baud_cnt_q <= '0;
      else                                      baud_cnt_q <= baud_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin search: first valid lane at or after ptr, wrapping.
  // ---------------------------------------------------------------------------
  always_comb begin
    int lane_int;
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    lane_int    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      lane_int = int'(ptr_q) + k;
      if (lane_int >= N_REQ) lane_int = lane_int - N_REQ;
      if (!grant_found && req_valid[IDW'(lane_int)]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(lane_int);
      end
    end
  end

  // Pointer moves past the winner, so idle lanes are skipped without penalty.
  always_comb begin
    ptr_d = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  assign accept    = (state_q == IDLE) && grant_found;
  // Gated with reset_n so the accept strobe is quiet while reset is held.
  assign req_ready = (reset_n && accept) ? (N_REQ'(1) << grant_idx) : '0;

  // ---------------------------------------------------------------------------
  // Scheduler FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      to_cnt_q <= '0;
      send_q   <= 1'b0;
      data_q   <= '0;
      parity_q <= 1'b0;
      grant_q  <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            data_q   <= req_data[8*grant_idx +: 8];
            parity_q <= parity_cfg;
            grant_q  <= grant_idx;
            ptr_q    <= ptr_d;
            send_q   <= 1'b1;
            to_cnt_q <= '0;
            state_q  <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (tx_busy) begin
            send_q <= 1'b0;
            if (tx_done) begin
              // Very short frame: start and completion seen together.
              done_q  <= N_REQ'(1) << grant_q;
              state_q <= IDLE;
            end else begin
              state_q <= WAIT_DONE;
            end
          end else if (to_cnt_q == TW'(LAUNCH_TIMEOUT - 1)) begin
            send_q  <= 1'b0;
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          // A tx_busy drop without tx_done is not treated as completion.
          if (tx_done) begin
            done_q  <= N_REQ'(1) << grant_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign baud_tick     = baud_tick_q;
  assign send_request  = send_q;
  assign tx_data       = data_q;
  assign parity_enable = parity_q;
  assign grant_id      = grant_q;
  assign req_done      = done_q;
  assign err_timeout   = err_q;
  assign sched_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sched
//   Directed bench for uart_tx_sched (N_REQ=4, CLKS_PER_BAUD=55,
//   LAUNCH_TIMEOUT=16). The bench plays the uart_tx side by hand.
//   Inputs change just after the falling edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_uart_tx_sched;

  localparam int N_REQ = 4;
  localparam int CPB   = 55;
  localparam int LTO   = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  req_done;
  logic        parity_cfg;
  logic        baud_tick;
  logic        send_request;
  logic [7:0]  tx_data;
  logic        parity_enable;
  logic        tx_busy;
  logic        tx_done;
  logic        sched_busy;
  logic [1:0]  grant_id;
  logic        err_timeout;

  int n_total = 0;
  int n_pass  = 0;

  uart_tx_sched #(
    .N_REQ(N_REQ), .CLKS_PER_BAUD(CPB), .LAUNCH_TIMEOUT(LTO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .req_done(req_done),
    .parity_cfg(parity_cfg), .baud_tick(baud_tick),
    .send_request(send_request), .tx_data(tx_data),
    .parity_enable(parity_enable),
    .tx_busy(tx_busy), .tx_done(tx_done),
    .sched_busy(sched_busy), .grant_id(grant_id),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Lane bytes: 0:A0 1:B1 2:55 3:C3
  localparam logic [31:0] LANE_BYTES = 32'hC355_B1A0;

  typedef struct {
    logic [3:0] valid;
    logic       par;
    int         exp_lane;
    logic [7:0] exp_data;
    bit         same_cycle_done;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Runs one full frame. Entry: just after a falling edge, FSM in IDLE,
  // req_valid/parity_cfg already driven. Exit: at the falling edge where
  // req_done is visible (FSM back in IDLE).
  task automatic do_frame(input int lane, input logic par, input logic [7:0] data,
                          input bit same_cycle_done, input bit keep_valid);
    logic [3:0] onehot;
    onehot = 4'(1 << lane);
    #1;
    check("ready_onehot", req_ready, onehot);
    @(negedge clk);
    check("send_req_rise", send_request, 1'b1);
    check("tx_data", tx_data, data);
    check("parity_en", parity_enable, par);
    check("grant_id", grant_id, lane);
    check("ready_zero_busy", req_ready, 4'b0);
    if (!keep_valid) req_valid = '0;
    parity_cfg = ~par;
    tx_busy    = 1'b1;
    if (same_cycle_done) tx_done = 1'b1;
    @(negedge clk);
    if (same_cycle_done) begin
      tx_busy = 1'b0;
      tx_done = 1'b0;
      check("done_same_cycle", req_done, onehot);
      check("idle_same_cycle", sched_busy, 1'b0);
      check("send_req_fall", send_request, 1'b0);
    end else begin
      check("send_req_fall", send_request, 1'b0);
      check("wait_no_done", req_done, 4'b0);
      repeat (3) @(negedge clk);
      tx_busy = 1'b0;
      @(negedge clk);
      check("busy_fall_ignored", sched_busy, 1'b1);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      check("req_done", req_done, onehot);
      check("back_idle", sched_busy, 1'b0);
    end
    check("parity_held", parity_enable, par);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int   first_tick, second_tick, n_ticks;
    int   err_at, err_cnt, send_low_at, done_seen;

    req_data   = LANE_BYTES;
    parity_cfg = 1'b0;
    do_reset();

    // ---- reset mid-LAUNCH, then baud timing and pointer after release ----
    @(negedge clk);
    req_valid = 4'b0100;
    @(negedge clk);
    check("pre_reset_send", send_request, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_send_async", send_request, 1'b0);
    check("rst_ready", req_ready, 4'b0);
    check("rst_busy", sched_busy, 1'b0);
    check("rst_txdata", tx_data, 8'h00);
    check("rst_grant", grant_id, 2'd0);
    check("rst_outs", {baud_tick, parity_enable, err_timeout, req_done}, 7'b0);
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
    first_tick = -1; second_tick = -1; n_ticks = 0;
    for (int n = 1; n <= 115; n++) begin
      @(negedge clk);
      if (baud_tick) begin
        n_ticks++;
        if (first_tick < 0) first_tick = n;
        else if (second_tick < 0) second_tick = n;
      end
    end
    check("baud_first", first_tick, CPB);
    check("baud_second", second_tick, 2 * CPB);
    check("baud_count", n_ticks, 2);
    req_valid = 4'b1111;
    #1;
    check("ptr_zero_after_rst", req_ready, 4'b0001);
    req_valid = '0;

    // ---- table-driven single frames, pointer chaining from ptr=0 ----
    vecs[0] = '{4'b0100, 1'b1, 2, 8'h55, 1'b0};
    vecs[1] = '{4'b0011, 1'b0, 0, 8'hA0, 1'b0};
    vecs[2] = '{4'b1001, 1'b1, 3, 8'hC3, 1'b1};
    vecs[3] = '{4'b0110, 1'b0, 1, 8'hB1, 1'b0};
    vecs[4] = '{4'b0001, 1'b1, 0, 8'hA0, 1'b0};
    vecs[5] = '{4'b1110, 1'b0, 1, 8'hB1, 1'b0};
    do_reset();
    @(negedge clk);
    check("idle_no_valid_ready", req_ready, 4'b0);
    for (int i = 0; i < 6; i++) begin
      req_valid  = vecs[i].valid;
      parity_cfg = vecs[i].par;
      do_frame(vecs[i].exp_lane, vecs[i].par, vecs[i].exp_data,
               vecs[i].same_cycle_done, 1'b0);
      @(negedge clk);
    end

    // ---- round-robin with all lanes valid ----
    do_reset();
    @(negedge clk);
    req_valid  = 4'b1111;
    parity_cfg = 1'b0;
    do_frame(0, 1'b0, 8'hA0, 1'b0, 1'b1);
    parity_cfg = 1'b0;
    do_frame(1, 1'b0, 8'hB1, 1'b0, 1'b1);
    parity_cfg = 1'b0;
    do_frame(2, 1'b0, 8'h55, 1'b0, 1'b1);
    parity_cfg = 1'b0;
    do_frame(3, 1'b0, 8'hC3, 1'b0, 1'b1);
    parity_cfg = 1'b0;
    do_frame(0, 1'b0, 8'hA0, 1'b0, 1'b0);

    // ---- launch timeout: tx_busy never rises ----
    do_reset();
    @(negedge clk);
    req_valid  = 4'b0100;
    parity_cfg = 1'b0;
    #1;
    check("to_ready", req_ready, 4'b0100);
    @(negedge clk);
    check("to_send_rise", send_request, 1'b1);
    req_valid = '0;
    err_at = -1; err_cnt = 0; send_low_at = -1; done_seen = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (err_timeout) begin
        err_cnt++;
        if (err_at < 0) err_at = k;
      end
      if (!send_request && send_low_at < 0) send_low_at = k;
      if (req_done != 4'b0) done_seen++;
      if (k == LTO) check("to_idle", sched_busy, 1'b0);
    end
    check("to_err_at", err_at, LTO);
    check("to_err_once", err_cnt, 1);
    check("to_send_fall", send_low_at, LTO);
    check("to_no_done", done_seen, 0);

    // ---- back-to-back: lanes 1 and 3 ----
    do_reset();
    @(negedge clk);
    req_valid  = 4'b1010;
    parity_cfg = 1'b1;
    do_frame(1, 1'b1, 8'hB1, 1'b0, 1'b1);
    req_valid  = 4'b1000;
    parity_cfg = 1'b1;
    do_frame(3, 1'b1, 8'hC3, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("b2b_data_held", tx_data, 8'hC3);
    check("b2b_grant_held", grant_id, 2'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
